rida_multicycle_sequencer: RTL and testbench
============================================

Name: rida_multicycle_sequencer

Overview:
- Multi-cycle control FSM for the RIDA CPU datapath.
- Sequences fetch, decode, execute, memory access and writeback for each instruction.
- Evaluates the 2-bit condition field against registered N/Z flags, and gates register, memory and PC writes when the condition fails.
- Sits beside the combinational instruction decoder: takes its decoded fields plus memory handshake signals and drives per-cycle enables.

Parameters:
- WAIT_MAX, 15, max consecutive cycles waiting on mem_ready before a fault (1..255).
- RET_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; leaves IDLE and begins fetching.
- cond  in  2  instruction condition: 00 AL, 01 EQ (Z=1), 10 NE (Z=0), 11 LT (N=1).
- tipo  in  2  instruction type: 00 REG, 01 IMM, 10 MEM, 11 CTRL.
- opcode  in  3  operation; for MEM: 000 LDR, 001 STR; for CTRL: 000 B, 111 HALT.
- alu_n  in  1  ALU negative result (combinational, current execute).
- alu_z  in  1  ALU zero result.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid (fetch or data).
- mem_we  out  1  write qualifier for mem_req (STR data phase only).
- ir_write  out  1  latch instruction register.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+1, 1 = branch target.
- reg_write  out  1  register file write enable.
- result_src  out  1  0 = ALU result, 1 = memory read data.
- flags_n, flags_z  out  1 each  registered flags.
- busy  out  1  high in every state except IDLE, HALTED and FAULT.
- fault  out  1  sticky memory-timeout indication.
- retired  out  RET_W  count of completed instructions, including condition-failed ones.

Behaviour:
- Reset: state=IDLE; all outputs 0; flags 0; retired 0; wait counter 0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, FAULT.
- IDLE -> FETCH on start; otherwise hold.
- FETCH:
  - mem_req=1, mem_we=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - One cycle, no enables.
  - Computes pass = cond check against flags_n/flags_z.
  - Registers tipo/opcode/pass for later states.
  - Goes to EXEC.
- EXEC, CTRL type:
  - opcode 111 -> HALTED regardless of condition; retired increments.
  - opcode 000 with pass -> pc_write=1, pc_src=1, retired++, go to FETCH.
  - Failed or other opcode -> retired++, go to FETCH.
- EXEC, REG/IMM type: if pass, go to WB; else retired++ and go to FETCH.
- EXEC, MEM type: if pass, go to MEM; else retired++ and go to FETCH.
- Flags:
  - Updated from alu_n/alu_z on the EXEC cycle only.
  - Update occurs for REG/IMM with pass=1.
  - Never updated by MEM or CTRL instructions.
- MEM:
  - mem_req=1; mem_we=1 for STR.
  - On mem_ready: LDR -> WB; STR -> retired++, go to FETCH.
- WB:
  - reg_write=1 for one cycle; result_src=1 if MEM/LDR, else 0.
  - retired++, go to FETCH.
- Wait counter (FETCH and MEM):
  - Counts cycles with mem_req=1 and mem_ready=0; clears on mem_ready or state change.
  - Reaching WAIT_MAX without ready -> FAULT; mem_req drops the next cycle.
  - A mem_ready arriving on the same cycle the count hits WAIT_MAX wins: no fault.
- FAULT: fault=1, all enables 0; exit only by rst.
- HALTED: enables 0; start restarts at FETCH (PC untouched); fault stays 0.
- start outside IDLE/HALTED is ignored.
- retired wraps modulo 2^RET_W.
- rst asserted mid-transaction:
  - Next state is IDLE, and mem_req is 0 that same edge.
  - No reg_write, mem_we or pc_write occurs in the reset cycle.
- Enables are Moore outputs of state plus registered pass/type, except mem_ready-qualified ir_write/pc_write in FETCH.
- Latencies with zero wait states:
  - REG/IMM: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B / failed condition: 3 cycles.

Decomposition:
- Package rida_ctrl_pkg holds:
  - enums for state, tipo (REG/IMM/MEM/CTRL) and cond (AL/EQ/NE/LT);
  - opcode constants OP_LDR, OP_STR, OP_B, OP_HALT;
  - function cond_pass(cond, n, z).
- One sub-module: rida_mem_wait_timer (wait counter plus timeout compare, parameterized by WAIT_MAX).
- FSM and output decode live in the top.

Test Plan:
1. rst, start, REG instr cond=AL, mem_ready=1 always -> ir_write@FETCH, reg_write@4th cycle, retired=1, back in FETCH on cycle 5.
2. Set Z=1 via a REG op with alu_z=1, then B cond=NE -> no pc_src=1 pulse, retired increments, 3-cycle instruction; repeat with cond=EQ -> pc_write & pc_src=1 in EXEC.
3. LDR with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles, then WB with result_src=1, reg_write=1 for exactly one cycle.
4. WAIT_MAX=4, mem_ready held 0 in FETCH -> FAULT entered after 4 wait cycles, fault=1 sticky, mem_req=0; start ignored; rst clears to IDLE.
5. HALT (tipo=11, op=111, cond=LT, N=0) -> HALTED, busy=0, retired incremented; start -> FETCH resumes.
6. rst asserted during MEM of STR -> next cycle IDLE, mem_we never asserted on the reset edge, all outputs 0.

Source files
------------

// File: rtl/rida_ctrl_pkg.sv
// Shared types and constants for the RIDA multi-cycle control path:
// FSM states, instruction type/condition encodings, opcodes and the condition check.
package rida_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALTED,
      S_FAULT
   } state_e;

   typedef enum logic [1:0] {
      T_REG  = 2'b00,
      T_IMM  = 2'b01,
      T_MEM  = 2'b10,
      T_CTRL = 2'b11
   } tipo_e;

   typedef enum logic [1:0] {
      C_AL = 2'b00,
      C_EQ = 2'b01,
      C_NE = 2'b10,
      C_LT = 2'b11
   } cond_e;

   localparam logic [2:0] OP_LDR  = 3'b000;
   localparam logic [2:0] OP_STR  = 3'b001;
   localparam logic [2:0] OP_B    = 3'b000;
   localparam logic [2:0] OP_HALT = 3'b111;

   function automatic logic cond_pass(input cond_e c, input logic n, input logic z);
      logic p;
      case (c)
         C_AL:    p = 1'b1;
         C_EQ:    p = z;
         C_NE:    p = ~z;
         C_LT:    p = n;
         default: p = 1'b0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/rida_mem_wait_timer.sv
// Counts consecutive un-acknowledged memory request cycles and flags a timeout
// on the WAIT_MAX-th such cycle; a ready on that same cycle suppresses the timeout.
module rida_mem_wait_timer #(
   parameter int WAIT_MAX = 15
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic active_i,
   input  logic ready_i,
   output logic timeout_o
);

   localparam logic [7:0] LIMIT = 8'(WAIT_MAX - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   always_comb begin
      cnt_d = 8'd0;
      if (active_i && !ready_i) cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= 8'd0;
      else       cnt_q <= cnt_d;
   end

   assign timeout_o = active_i && !ready_i && (cnt_q == LIMIT);

endmodule

// File: rtl/rida_multicycle_sequencer.sv
// Multi-cycle control FSM for the RIDA datapath: fetch/decode/exec/mem/wb sequencing,
// condition gating against registered N/Z flags, memory wait timeout and retire count.
module rida_multicycle_sequencer
   import rida_ctrl_pkg::*;
#(
   parameter int WAIT_MAX = 15,
   parameter int RET_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       cond,
   input  logic [1:0]       tipo,
   input  logic [2:0]       opcode,
   input  logic             alu_n,
   input  logic             alu_z,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             reg_write,
   output logic             result_src,
   output logic             flags_n,
   output logic             flags_z,
   output logic             busy,
   output logic             fault,
   output logic [RET_W-1:0] retired,
   output logic [2:0]       dbg_state_o
);

   state_e           state_q;
   tipo_e            tipo_q;
   logic [2:0]       op_q;
   logic             pass_q;
   logic             n_q;
   logic             z_q;
   logic [RET_W-1:0] ret_q;
   logic             timeout;

   rida_mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
      .clk_i    (clk),
      .rst_i    (rst),
      .active_i (mem_req),
      .ready_i  (mem_ready),
      .timeout_o(timeout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         tipo_q  <= T_REG;
         op_q    <= 3'd0;
         pass_q  <= 1'b0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
         ret_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE:   if (start) state_q <= S_FETCH;
            S_FETCH: begin
               if (mem_ready)    state_q <= S_DECODE;
               else if (timeout) state_q <= S_FAULT;
            end
            S_DECODE: begin
               tipo_q  <= tipo_e'(tipo);
               op_q    <= opcode;
               pass_q  <= cond_pass(cond_e'(cond), n_q, z_q);
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               case (tipo_q)
                  T_CTRL: begin
                     ret_q   <= ret_q + RET_W'(1);
                     state_q <= (op_q == OP_HALT) ? S_HALTED : S_FETCH;
                  end
                  T_MEM: begin
                     if (pass_q) state_q <= S_MEM;
                     else begin
                        ret_q   <= ret_q + RET_W'(1);
                        state_q <= S_FETCH;
                     end
                  end
                  default: begin
                     if (pass_q) begin
                        n_q     <= alu_n;
                        z_q     <= alu_z;
                        state_q <= S_WB;
                     end else begin
                        ret_q   <= ret_q + RET_W'(1);
                        state_q <= S_FETCH;
                     end
                  end
               endcase
            end
            S_MEM: begin
               if (mem_ready) begin
                  if (op_q == OP_STR) begin
                     ret_q   <= ret_q + RET_W'(1);
                     state_q <= S_FETCH;
                  end else begin
                     state_q <= S_WB;
                  end
               end else if (timeout) begin
                  state_q <= S_FAULT;
               end
            end
            S_WB: begin
               ret_q   <= ret_q + RET_W'(1);
               state_q <= S_FETCH;
            end
            S_HALTED: if (start) state_q <= S_FETCH;
            S_FAULT:  state_q <= S_FAULT;
            default:  state_q <= S_IDLE;
         endcase
      end
   end

   // Outputs are forced low while rst is high so a mid-transaction reset never
   // lets a write or request escape during the reset cycle.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      result_src = 1'b0;
      busy       = 1'b0;
      fault      = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               mem_req  = 1'b1;
               ir_write = mem_ready;
               pc_write = mem_ready;
               busy     = 1'b1;
            end
            S_DECODE: busy = 1'b1;
            S_EXEC: begin
               busy = 1'b1;
               if (tipo_q == T_CTRL && op_q == OP_B && pass_q) begin
                  pc_write = 1'b1;
                  pc_src   = 1'b1;
               end
            end
            S_MEM: begin
               mem_req = 1'b1;
               mem_we  = (op_q == OP_STR);
               busy    = 1'b1;
            end
            S_WB: begin
               reg_write  = 1'b1;
               result_src = (tipo_q == T_MEM);
               busy       = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: ;
         endcase
      end
   end

   assign flags_n     = n_q;
   assign flags_z     = z_q;
   assign retired     = ret_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rida_multicycle_sequencer.sv
// Bench for rida_multicycle_sequencer: per-instruction expected cycle traces are built
// from the instruction rules into a queue, then replayed against the DUT cycle by cycle.
module tb_rida_multicycle_sequencer;

   localparam int WM = 4;
   localparam int RW = 4;

   localparam logic [1:0] REG  = 2'b00;
   localparam logic [1:0] IMM  = 2'b01;
   localparam logic [1:0] MEMT = 2'b10;
   localparam logic [1:0] CTRL = 2'b11;
   localparam logic [1:0] AL = 2'b00, EQ = 2'b01, NE = 2'b10, LT = 2'b11;

   // {mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, result_src, busy, fault}
   localparam logic [8:0] V_IDLE  = 9'b000000000;
   localparam logic [8:0] V_BUSY  = 9'b000000010;
   localparam logic [8:0] V_FWAIT = 9'b100000010;
   localparam logic [8:0] V_FHIT  = 9'b101100010;
   localparam logic [8:0] V_BR    = 9'b000110010;
   localparam logic [8:0] V_LD    = 9'b100000010;
   localparam logic [8:0] V_ST    = 9'b110000010;
   localparam logic [8:0] V_WBR   = 9'b000001010;
   localparam logic [8:0] V_WBL   = 9'b000001110;
   localparam logic [8:0] V_FAULT = 9'b000000001;

   logic          clk = 1'b0;
   logic          rst, start, alu_n, alu_z, mem_ready;
   logic [1:0]    cond, tipo;
   logic [2:0]    opcode;
   logic          mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, result_src;
   logic          flags_n, flags_z, busy, fault;
   logic [RW-1:0] retired;
   logic [2:0]    dbg_state;

   rida_multicycle_sequencer #(.WAIT_MAX(WM), .RET_W(RW)) dut (
      .clk(clk), .rst(rst), .start(start), .cond(cond), .tipo(tipo), .opcode(opcode),
      .alu_n(alu_n), .alu_z(alu_z), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
      .pc_src(pc_src), .reg_write(reg_write), .result_src(result_src),
      .flags_n(flags_n), .flags_z(flags_z), .busy(busy), .fault(fault),
      .retired(retired), .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [8:0]    exp_q[$];
   logic          rdy_q[$];
   string         tag_q[$];
   logic          m_n, m_z;
   logic [RW-1:0] m_ret;

   task automatic check(input logic [8:0] exp, input string tag);
      logic [8:0] obs;
      obs = {mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, result_src, busy, fault};
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_arch(input string tag);
      n_checks++;
      assert ({flags_n, flags_z, retired} === {m_n, m_z, m_ret}) else begin
         n_fail++;
         $error("FAIL %s observed n=%b z=%b ret=%0d expected n=%b z=%b ret=%0d",
                tag, flags_n, flags_z, retired, m_n, m_z, m_ret);
      end
   endtask

   task automatic step(input logic [8:0] exp, input string tag);
      @(negedge clk);
      check(exp, tag);
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [8:0] exp, input logic rdy, input string tag);
      exp_q.push_back(exp);
      rdy_q.push_back(rdy);
      tag_q.push_back(tag);
   endtask

   // start is randomized while busy: it must be ignored outside IDLE/HALTED.
   task automatic play();
      logic [8:0] e;
      string      t;
      while (exp_q.size() > 0) begin
         mem_ready = rdy_q.pop_front();
         start     = 1'($urandom_range(0, 1));
         e         = exp_q.pop_front();
         t         = tag_q.pop_front();
         step(e, t);
      end
      start = 1'b0;
   endtask

   function automatic logic cond_ok(input logic [1:0] c);
      case (c)
         AL:      return 1'b1;
         EQ:      return m_z;
         NE:      return ~m_z;
         default: return m_n;
      endcase
   endfunction

   task automatic model_reset();
      m_n   = 1'b0;
      m_z   = 1'b0;
      m_ret = '0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step(V_IDLE, "start_pulse");
      start = 1'b0;
   endtask

   // Runs one instruction from FETCH; fw/mw are wait cycles before mem_ready.
   task automatic run_instr(input logic [1:0] tp, input logic [1:0] cd, input logic [2:0] op,
                            input int fw, input int mw, input logic an, input logic az);
      logic pass;
      logic halt;
      pass   = cond_ok(cd);
      halt   = 1'b0;
      tipo   = tp;
      cond   = cd;
      opcode = op;
      alu_n  = an;
      alu_z  = az;
      repeat (fw) push(V_FWAIT, 1'b0, "fetch_wait");
      push(V_FHIT, 1'b1, "fetch_hit");
      push(V_BUSY, 1'($urandom_range(0, 1)), "decode");
      push((tp == CTRL && op == 3'b000 && pass) ? V_BR : V_BUSY, 1'($urandom_range(0, 1)), "exec");
      if (tp == CTRL) begin
         halt = (op == 3'b111);
      end else if (pass && tp == MEMT) begin
         repeat (mw) push((op == 3'b001) ? V_ST : V_LD, 1'b0, "mem_wait");
         push((op == 3'b001) ? V_ST : V_LD, 1'b1, "mem_hit");
         if (op == 3'b000) push(V_WBL, 1'($urandom_range(0, 1)), "wb_load");
      end else if (pass) begin
         m_n = an;
         m_z = az;
         push(V_WBR, 1'($urandom_range(0, 1)), "wb_alu");
      end
      m_ret = m_ret + 1'b1;
      play();
      check_arch("arch_after_instr");
      if (halt) begin
         step(V_IDLE, "halted");
         step(V_IDLE, "halted_hold");
         do_start();
      end
   endtask

   initial begin
      logic [1:0] tp, cd;
      logic [2:0] op;
      rst = 1'b1; start = 1'b0; mem_ready = 1'b0;
      cond = 2'b00; tipo = 2'b00; opcode = 3'b000; alu_n = 1'b0; alu_z = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      step(V_IDLE, "in_reset");
      rst = 1'b0;
      check_arch("reset_arch");
      n_checks++;
      assert (dbg_state === 3'd0) else begin
         n_fail++;
         $error("FAIL reset_state observed=%0d expected=0", dbg_state);
      end
      step(V_IDLE, "idle_hold");
      do_start();

      // REG, REG setting Z, B NE (fails), B EQ (taken)
      run_instr(REG, AL, 3'b010, 0, 0, 1'b1, 1'b0);
      run_instr(REG, AL, 3'b000, 0, 0, 1'b0, 1'b1);
      run_instr(CTRL, NE, 3'b000, 0, 0, 1'b1, 1'b1);
      run_instr(CTRL, EQ, 3'b000, 0, 0, 1'b1, 1'b1);
      // LDR with 3 memory waits, STR with last-allowed fetch wait
      run_instr(MEMT, AL, 3'b000, 0, 3, 1'b1, 1'b1);
      run_instr(MEMT, AL, 3'b001, WM - 1, 0, 1'b0, 1'b0);
      // N=0 then HALT with cond LT must still halt
      run_instr(IMM, AL, 3'b000, 0, 0, 1'b0, 1'b0);
      run_instr(CTRL, LT, 3'b111, 0, 0, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         tp = 2'($urandom_range(0, 3));
         cd = 2'($urandom_range(0, 3));
         op = (tp == MEMT) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
         run_instr(tp, cd, op, $urandom_range(0, WM - 1), $urandom_range(0, WM - 1),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // reset during the data phase of a STR
      tipo = MEMT; cond = AL; opcode = 3'b001;
      push(V_FHIT, 1'b1, "str_fetch");
      push(V_BUSY, 1'b0, "str_decode");
      push(V_BUSY, 1'b0, "str_exec");
      push(V_ST, 1'b0, "str_mem");
      play();
      rst = 1'b1;
      mem_ready = 1'b1;
      step(V_IDLE, "rst_cycle_outputs");
      rst = 1'b0;
      model_reset();
      check_arch("arch_after_mid_rst");
      step(V_IDLE, "idle_after_mid_rst");

      // memory timeout in FETCH
      do_start();
      tipo = REG; cond = AL; opcode = 3'b000;
      repeat (WM) push(V_FWAIT, 1'b0, "fault_wait");
      push(V_FAULT, 1'b0, "fault_enter");
      push(V_FAULT, 1'b1, "fault_sticky");
      push(V_FAULT, 1'b0, "fault_sticky");
      play();
      start = 1'b1;
      step(V_FAULT, "fault_ignores_start");
      start = 1'b0;
      rst = 1'b1;
      step(V_IDLE, "fault_rst_cycle");
      rst = 1'b0;
      check_arch("arch_after_fault_rst");
      step(V_IDLE, "idle_after_fault");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
